fir_sequencer: RTL and testbench

- Control FSM for the FIR filter datapath: a 16-entry register file plus an ALU with ops COPY, LOAD1, LOAD2, ADD, SUB and MUL.
- Sequences coefficient loading and per-sample shift/multiply-accumulate.
- Drives the modwait/err handshake and the sample-counter increment.
- Sits between the input synchronizers (dr, lc) and the datapath/counter inside the filter top level.

---
 rtl/fir_sequencer.sv | 179 +++++++++++++++++
 tb/tb_fir_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sequencer.sv
// fir_sequencer: control FSM for the FIR datapath (16-entry register file + ALU).
// Sequences coefficient loads and per-sample shift / multiply-accumulate, and
// drives the modwait/err handshake plus the sample-counter strobes.
// Optional feature macro: FIR_ALT_SIGN_EN (alternating-sign accumulation).
module fir_sequencer #(
    parameter int unsigned NUM_TAPS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       dr,
    input  logic       lc,
    input  logic       overflow,
    output logic       cnt_up,
    output logic       clear,
    output logic       modwait,
    output logic [2:0] op,
    output logic [3:0] src1,
    output logic [3:0] src2,
    output logic [3:0] dest,
    output logic       err
);

    localparam logic [3:0] N         = 4'(NUM_TAPS);
    localparam logic [3:0] RegCoef   = 4'(NUM_TAPS + 1);
    localparam logic [3:0] RegTmp    = 4'(2 * NUM_TAPS + 1);
    localparam logic [2:0] CidxLast  = 3'(NUM_TAPS - 1);

    localparam logic [2:0] OpNop   = 3'b000;
    localparam logic [2:0] OpCopy  = 3'b001;
    localparam logic [2:0] OpLoad1 = 3'b010;
    localparam logic [2:0] OpLoad2 = 3'b011;
    localparam logic [2:0] OpAdd   = 3'b100;
    localparam logic [2:0] OpSub   = 3'b101;
    localparam logic [2:0] OpMul   = 3'b110;

`ifdef FIR_ALT_SIGN_EN
    localparam logic AltSign = 1'b1;
`else
    localparam logic AltSign = 1'b0;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StStore,
        StMul,
        StAcc,
        StEidle,
        StLoadc,
        StWaitc
    } state_e;

    state_e     state_q, state_d;
    // idx_q is the shift position k in StShift and the tap index in StMul/StAcc
    logic [3:0] idx_q, idx_d;
    logic [2:0] cidx_q, cidx_d;
    logic       busy_d;

    // State, index and registered busy flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 4'd0;
            cidx_q  <= 3'd0;
            modwait <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cidx_q  <= cidx_d;
            modwait <= busy_d;
        end
    end

    // Next-state logic; aborts on dr loss (shift/store) or overflow (mul/acc)
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cidx_d  = cidx_q;
        unique case (state_q)
            StIdle, StEidle: begin
                if (dr) begin
                    state_d = StShift;
                    idx_d   = N;
                end else if (lc) begin
                    state_d = StLoadc;
                end
            end
            StShift: begin
                if (!dr) begin
                    state_d = StEidle;
                end else if (idx_q == 4'd2) begin
                    state_d = StStore;
                end else begin
                    idx_d = idx_q - 4'd1;
                end
            end
            StStore: begin
                if (!dr) begin
                    state_d = StEidle;
                end else begin
                    state_d = StMul;
                    idx_d   = 4'd0;
                end
            end
            StMul: begin
                if (overflow) begin
                    state_d = StEidle;
                end else if (idx_q == 4'd0) begin
                    // tap 0 multiplies straight into R0, no accumulate step
                    idx_d = 4'd1;
                end else begin
                    state_d = StAcc;
                end
            end
            StAcc: begin
                if (overflow) begin
                    state_d = StEidle;
                end else if (idx_q == N - 4'd1) begin
                    state_d = StIdle;
                end else begin
                    state_d = StMul;
                    idx_d   = idx_q + 4'd1;
                end
            end
            StLoadc: state_d = StWaitc;
            StWaitc: begin
                if (!lc) begin
                    state_d = StIdle;
                    cidx_d  = (cidx_q == CidxLast) ? 3'd0 : cidx_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = !(state_d inside {StIdle, StWaitc, StEidle});
    end

    // Datapath control decoded purely from the current state
    always_comb begin
        op     = OpNop;
        src1   = 4'd0;
        src2   = 4'd0;
        dest   = 4'd0;
        cnt_up = 1'b0;
        clear  = 1'b0;
        err    = 1'b0;
        unique case (state_q)
            StShift: begin
                op   = OpCopy;
                src1 = idx_q - 4'd1;
                dest = idx_q;
            end
            StStore: begin
                op     = OpLoad1;
                dest   = 4'd1;
                cnt_up = 1'b1;
            end
            StMul: begin
                op   = OpMul;
                src1 = idx_q + 4'd1;
                src2 = RegCoef + idx_q;
                dest = (idx_q == 4'd0) ? 4'd0 : RegTmp;
            end
            StAcc: begin
                op   = (AltSign && idx_q[0]) ? OpSub : OpAdd;
                src1 = 4'd0;
                src2 = RegTmp;
                dest = 4'd0;
            end
            StEidle: err = 1'b1;
            StLoadc: begin
                op    = OpLoad2;
                dest  = RegCoef + {1'b0, cidx_q};
                clear = (cidx_q == 3'd0);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fir_sequencer.sv
// Bench for fir_sequencer: directed scenarios plus random stimulus, checked every
// cycle against a queue-based behavioural model of the control sequence.
module tb_fir_sequencer;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       reset, dr, lc, overflow;
    logic       cnt_up, clear, modwait, err;
    logic [2:0] op;
    logic [3:0] src1, src2, dest;

    always #5 clk = ~clk;

    fir_sequencer #(.NUM_TAPS(N)) dut (
        .clk      (clk),
        .reset    (reset),
        .dr       (dr),
        .lc       (lc),
        .overflow (overflow),
        .cnt_up   (cnt_up),
        .clear    (clear),
        .modwait  (modwait),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .dest     (dest),
        .err      (err)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int op;
        int s1;
        int s2;
        int d;
        int cnt;
        int mac;
    } uop_t;

    localparam int MIdle = 0, MEidle = 1, MSeq = 2, MLoadc = 3, MWaitc = 4;

`ifdef FIR_ALT_SIGN_EN
    localparam bit Alt = 1'b1;
`else
    localparam bit Alt = 1'b0;
`endif

    int   mode = MIdle;
    int   cidx = 0;
    uop_t seq_q[$];

    function automatic uop_t mk(int o, int a, int b, int d, int c, int m);
        uop_t u;
        u.op = o; u.s1 = a; u.s2 = b; u.d = d; u.cnt = c; u.mac = m;
        return u;
    endfunction

    // The whole per-sample program as a list of register-file operations
    task automatic start_seq();
        seq_q.delete();
        for (int k = N; k >= 2; k--) seq_q.push_back(mk(1, k - 1, 0, k, 0, 0));
        seq_q.push_back(mk(2, 0, 0, 1, 1, 0));
        seq_q.push_back(mk(6, 1, N + 1, 0, 0, 1));
        for (int k = 1; k < N; k++) begin
            seq_q.push_back(mk(6, k + 1, N + 1 + k, 2 * N + 1, 0, 1));
            seq_q.push_back(mk((Alt && (k % 2 == 1)) ? 5 : 4, 0, 2 * N + 1, 0, 0, 1));
        end
        mode = MSeq;
    endtask

    always @(posedge clk) begin
        if (reset) begin
            mode = MIdle;
            cidx = 0;
            seq_q.delete();
        end else begin
            case (mode)
                MIdle, MEidle: begin
                    if (dr) start_seq();
                    else if (lc) mode = MLoadc;
                end
                MSeq: begin
                    if ((seq_q[0].mac == 0 && !dr) || (seq_q[0].mac == 1 && overflow)) begin
                        mode = MEidle;
                        seq_q.delete();
                    end else begin
                        void'(seq_q.pop_front());
                        if (seq_q.size() == 0) mode = MIdle;
                    end
                end
                MLoadc: mode = MWaitc;
                MWaitc: begin
                    if (!lc) begin
                        cidx = (cidx + 1) % N;
                        mode = MIdle;
                    end
                end
                default: mode = MIdle;
            endcase
        end
    end

    // ---------------- compare and tally ----------------
    int mw_cnt, clr_cnt, cup_cnt;
    int obs_op[$];
    int obs_dest[$];

    task automatic tally_clear();
        mw_cnt = 0; clr_cnt = 0; cup_cnt = 0;
        obs_op.delete();
        obs_dest.delete();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int e_op, e_s1, e_s2, e_d, e_cnt, e_clr, e_err, e_mw;
            e_op = 0; e_s1 = 0; e_s2 = 0; e_d = 0; e_cnt = 0; e_clr = 0; e_err = 0;
            e_mw = (mode == MSeq || mode == MLoadc) ? 1 : 0;
            case (mode)
                MEidle: e_err = 1;
                MSeq: begin
                    e_op = seq_q[0].op; e_s1 = seq_q[0].s1; e_s2 = seq_q[0].s2;
                    e_d = seq_q[0].d; e_cnt = seq_q[0].cnt;
                end
                MLoadc: begin
                    e_op = 3; e_d = N + 1 + cidx; e_clr = (cidx == 0) ? 1 : 0;
                end
                default: ;
            endcase
            check("op", int'(op), e_op);
            check("src1", int'(src1), e_s1);
            check("src2", int'(src2), e_s2);
            check("dest", int'(dest), e_d);
            check("cnt_up", int'(cnt_up), e_cnt);
            check("clear", int'(clear), e_clr);
            check("err", int'(err), e_err);
            check("modwait", int'(modwait), e_mw);
            mw_cnt  += int'(modwait);
            clr_cnt += int'(clear);
            cup_cnt += int'(cnt_up);
            if (op != 3'd0) begin
                obs_op.push_back(int'(op));
                obs_dest.push_back(int'(dest));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One full sample: dr held through STORE, then released
    task automatic run_sample();
        dr = 1'b1;
        cyc(5);
        dr = 1'b0;
        cyc(10);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_dest[11];
        int exp_op[11];
        int ld_exp[5];
        exp_dest = '{4, 3, 2, 1, 0, 9, 0, 9, 0, 9, 0};
        if (Alt) exp_op = '{1, 1, 1, 2, 6, 6, 5, 6, 4, 6, 5};
        else     exp_op = '{1, 1, 1, 2, 6, 6, 4, 6, 4, 6, 4};
        ld_exp = '{5, 6, 7, 8, 5};

        reset = 1'b1; dr = 1'b0; lc = 1'b0; overflow = 1'b0;
        tally_clear();
        cyc(2);
        reset = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_op", int'(op), 0);
        check("rst_modwait", int'(modwait), 0);
        check("rst_err", int'(err), 0);
        cyc(1);

        // Coefficient loads: five 2-cycle lc pulses
        tally_clear();
        for (int p = 0; p < 5; p++) begin
            lc = 1'b1; cyc(2);
            lc = 1'b0; cyc(2);
        end
        check("ld_count", obs_op.size(), 5);
        for (int i = 0; i < obs_op.size() && i < 5; i++) begin
            check("ld_op", obs_op[i], 3);
            check("ld_dest", obs_dest[i], ld_exp[i]);
        end
        check("ld_modwait_cycles", mw_cnt, 5);
        check("ld_clear_pulses", clr_cnt, 2);

        // Full sample sequence
        tally_clear();
        run_sample();
        check("smp_len", obs_op.size(), 11);
        for (int i = 0; i < obs_op.size() && i < 11; i++) begin
            check("smp_op", obs_op[i], exp_op[i]);
            check("smp_dest", obs_dest[i], exp_dest[i]);
        end
        check("smp_modwait_cycles", mw_cnt, 11);
        check("smp_cnt_up", cup_cnt, 1);

        // dr dropped on the second SHIFT cycle
        tally_clear();
        dr = 1'b1; cyc(2);
        dr = 1'b0; cyc(1);
        @(negedge clk);
        check("abort_err", int'(err), 1);
        check("abort_modwait", int'(modwait), 0);
        check("abort_cnt_up", cup_cnt, 0);
        cyc(1);
        tally_clear();
        dr = 1'b1; cyc(5);
        dr = 1'b0;
        @(negedge clk);
        check("recover_err", int'(err), 0);
        cyc(10);
        check("recover_modwait_cycles", mw_cnt, 11);
        check("recover_cnt_up", cup_cnt, 1);

        // Overflow during the accumulate of tap 2
        tally_clear();
        dr = 1'b1; cyc(5);
        dr = 1'b0; cyc(4);
        overflow = 1'b1; cyc(1);
        overflow = 1'b0;
        @(negedge clk);
        check("ovf_err", int'(err), 1);
        check("ovf_op", int'(op), 0);
        cyc(3);
        check("ovf_writes", obs_op.size(), 9);
        check("ovf_modwait_cycles", mw_cnt, 9);

        // dr and lc together: sample first, then the pending coefficient load
        run_sample();
        tally_clear();
        dr = 1'b1; lc = 1'b1; cyc(5);
        dr = 1'b0; cyc(10);
        lc = 1'b0; cyc(3);
        check("both_len", obs_op.size(), 12);
        if (obs_op.size() == 12) begin
            check("both_ld_op", obs_op[11], 3);
            check("both_ld_dest", obs_dest[11], 6);
        end
        check("both_cnt_up", cup_cnt, 1);
        check("both_clear", clr_cnt, 0);

        // Reset in the middle of a MUL state
        dr = 1'b1; cyc(5);
        dr = 1'b0; cyc(1);
        reset = 1'b1; cyc(2);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_op", int'(op), 0);
        check("midrst_modwait", int'(modwait), 0);
        check("midrst_err", int'(err), 0);
        check("midrst_dest", int'(dest), 0);
        cyc(1);
        tally_clear();
        lc = 1'b1; cyc(2);
        lc = 1'b0; cyc(2);
        check("midrst_ld_count", obs_dest.size(), 1);
        if (obs_dest.size() == 1) check("midrst_ld_dest", obs_dest[0], 5);
        check("midrst_clear", clr_cnt, 1);

        // Random stimulus against the model
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) dr = ~dr;
            if ($urandom_range(0, 9) == 0) lc = ~lc;
            overflow = ($urandom_range(0, 23) == 0);
            reset    = ($urandom_range(0, 299) == 0);
            cyc(1);
        end
        reset = 1'b0; dr = 1'b0; lc = 1'b0; overflow = 1'b0;
        cyc(2);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
